// File: rtl/yasac_pkg.sv
// Shared definitions for the YASAC run controller and the system-level state decoder.
// Holds the controller state encoding and the helper that picks the active mode.
package yasac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } run_state_e;

    // Mode entered when execution begins or resumes.
    function automatic run_state_e active_mode(input logic step_mode);
        return step_mode ? ST_STEP : ST_RUN;
    endfunction

endpackage

// File: rtl/yasac_run_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one asynchronous button.
// The pulse is high for one cycle, in the cycle after the second clk edge that sees the rise.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    // sh_q[0]/sh_q[1] form the synchronizer, sh_q[2] remembers the previous synchronized level
    logic [2:0] sh_q;
    logic [2:0] sh_d;

    // Next value of the synchronizer / edge history chain.
    always_comb begin
        sh_d = {sh_q[1:0], din};
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/yasac_run_ctrl.sv
// Run/step/halt controller generating the processor clock enable and start strobe.
// Button events are synchronized, a free-running divider provides the run-mode tick.
module yasac_run_ctrl
    import yasac_pkg::*;
#(
    parameter int unsigned DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic       halt,
    input  logic       step_mode,
    input  logic       cpu_ready,
    output logic       cpu_ce,
    output logic       cpu_start,
    output logic [1:0] state_out,
    output logic       busy
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic          start_e_s;
    logic          step_e_s;
    logic          halt_e_s;
    logic          tick_s;
    logic          done_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    run_state_e    state_q;
    run_state_e    state_d;
    logic          start_pend_q;
    logic          start_pend_d;
    logic          cpu_ce_q;
    logic          cpu_ce_d;
    logic          cpu_start_q;
    logic          cpu_start_d;
    logic          busy_q;
    logic          busy_d;

    sync_edge u_sync_start (.clk(clk), .reset(reset), .din(start), .pulse(start_e_s));
    sync_edge u_sync_step  (.clk(clk), .reset(reset), .din(step),  .pulse(step_e_s));
    sync_edge u_sync_halt  (.clk(clk), .reset(reset), .din(halt),  .pulse(halt_e_s));

    assign tick_s = (cnt_q == CNT_MAX);
    // The processor reports completion while it is being clocked.
    assign done_s = cpu_ce_q & cpu_ready;

    // Tick divider wraps at DIV-1 regardless of controller state.
    always_comb begin
        if (tick_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Tick divider register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Next-state, clock-enable and start-strobe decision; earlier branches win on collisions.
    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        cpu_ce_d     = 1'b0;
        cpu_start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_ce_d = tick_s;
                if (tick_s && start_pend_q) begin
                    cpu_start_d  = 1'b1;
                    start_pend_d = 1'b0;
                    state_d      = active_mode(step_mode);
                end else if (start_e_s) begin
                    start_pend_d = 1'b1;
                end else begin
                    start_pend_d = start_pend_q;
                end
            end
            ST_RUN: begin
                cpu_ce_d = tick_s;
                if (done_s) begin
                    state_d = ST_IDLE;
                end else if (halt_e_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_ce_d = step_e_s;
                if (done_s) begin
                    state_d = ST_IDLE;
                end else if (halt_e_s) begin
                    state_d = ST_HALT;
                end else if (!step_mode) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_HALT: begin
                cpu_ce_d = step_e_s;
                if (start_e_s) begin
                    state_d = active_mode(step_mode);
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                start_pend_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            start_pend_q <= 1'b0;
            cpu_ce_q     <= 1'b0;
            cpu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_pend_q <= start_pend_d;
            cpu_ce_q     <= cpu_ce_d;
            cpu_start_q  <= cpu_start_d;
            busy_q       <= busy_d;
        end
    end

    assign cpu_ce    = cpu_ce_q;
    assign cpu_start = cpu_start_q;
    assign state_out = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_yasac_run_ctrl.sv
// Self-checking bench for yasac_run_ctrl with DIV=4: directed scenarios plus random stimulus,
// all compared against a cycle-level reference model built from history shift and modulo arithmetic.
module tb_yasac_run_ctrl;

    localparam int DIV = 4;
    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_STEP = 2'd2;
    localparam logic [1:0] M_HALT = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, step, halt, step_mode, cpu_ready;
    logic       cpu_ce, cpu_start, busy;
    logic [1:0] state_out;

    int n_chk = 0;
    int n_err = 0;

    yasac_run_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .halt(halt),
        .step_mode(step_mode), .cpu_ready(cpu_ready), .cpu_ce(cpu_ce),
        .cpu_start(cpu_start), .state_out(state_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: input levels seen at past edges, edges since reset, abstract mode.
    int         m_n;
    logic [2:0] m_hs, m_hp, m_hh;
    logic [1:0] m_mode;
    logic       m_pend, m_ce, m_cs;

    logic       e_start, e_step, e_halt, tk, done, fire, launch, pend_nx;
    logic [1:0] mode_nx;

    always_comb begin
        e_start = m_hs[1] && !m_hs[2];
        e_step  = m_hp[1] && !m_hp[2];
        e_halt  = m_hh[1] && !m_hh[2];
        tk      = (m_n % DIV) == DIV - 1;
        done    = m_ce && cpu_ready;
        fire    = (m_mode == M_IDLE || m_mode == M_RUN) ? tk : e_step;
        launch  = (m_mode == M_IDLE) && fire && m_pend;
        mode_nx = m_mode;
        pend_nx = m_pend;
        if (m_mode == M_IDLE) begin
            if (launch) begin
                mode_nx = step_mode ? M_STEP : M_RUN;
                pend_nx = 1'b0;
            end else if (e_start) begin
                pend_nx = 1'b1;
            end
        end else if (m_mode != M_HALT && done) begin
            mode_nx = M_IDLE;
        end else if (m_mode != M_HALT && e_halt) begin
            mode_nx = M_HALT;
        end else if (m_mode == M_STEP && !step_mode) begin
            mode_nx = M_RUN;
        end else if (m_mode == M_HALT && e_start) begin
            mode_nx = step_mode ? M_STEP : M_RUN;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n <= 0; m_hs <= 3'b000; m_hp <= 3'b000; m_hh <= 3'b000;
            m_mode <= M_IDLE; m_pend <= 1'b0; m_ce <= 1'b0; m_cs <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            m_hs <= {m_hs[1:0], start};
            m_hp <= {m_hp[1:0], step};
            m_hh <= {m_hh[1:0], halt};
            m_mode <= mode_nx; m_pend <= pend_nx; m_ce <= fire; m_cs <= launch;
        end
    end

    function automatic logic [4:0] exp_vec();
        return {m_mode, m_mode != M_IDLE, m_ce, m_cs};
    endfunction

    task automatic test_reset();
        int ce_cnt = 0;
        int bad = 0;
        reset = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0; step_mode = 1'b0; cpu_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({state_out, busy, cpu_ce, cpu_start} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_state: got %b expected 00000", {state_out, busy, cpu_ce, cpu_start});
        end
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            n_chk++;
            if ({state_out, busy, cpu_ce, cpu_start} !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_model cyc %0d: got %b expected %b", i, {state_out, busy, cpu_ce, cpu_start}, exp_vec());
            end
            if (cpu_ce) ce_cnt++;
            if (cpu_ce !== ((i % DIV) == 0)) bad++;
            if (state_out !== 2'b00 || busy !== 1'b0 || cpu_start !== 1'b0) bad++;
        end
        n_chk++;
        if (ce_cnt != 3 || bad != 0) begin
            n_err++;
            $display("FAIL idle_tick: got %0d pulses and %0d bad cycles, expected 3 pulses every 4 cycles", ce_cnt, bad);
        end
    endtask

    task automatic test_run_complete();
        int  cs_cnt = 0;
        bit  saw_run = 1'b0;
        step_mode = 1'b0;
        for (int i = 0; i < 40; i++) begin
            start = (i < 2);
            cpu_ready = (i >= 20);
            @(negedge clk);
            n_chk++;
            if ({state_out, busy, cpu_ce, cpu_start} !== exp_vec()) begin
                n_err++;
                $display("FAIL run_model cyc %0d: got %b expected %b", i, {state_out, busy, cpu_ce, cpu_start}, exp_vec());
            end
            if (cpu_start) begin
                cs_cnt++;
                if (cpu_ce && state_out == 2'b01) saw_run = 1'b1;
            end
        end
        cpu_ready = 1'b0;
        n_chk++;
        if (cs_cnt != 1 || !saw_run || state_out !== 2'b00) begin
            n_err++;
            $display("FAIL run_complete: got cpu_start count %0d in_run %0d final state %b, expected 1 1 00", cs_cnt, saw_run, state_out);
        end
    endtask

    task automatic test_step_mode();
        int ce_cnt = 0;
        step_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            start = (i < 2);
            @(negedge clk);
        end
        n_chk++;
        if (state_out !== 2'b10 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL step_enter: got state %b busy %b expected 10 1", state_out, busy);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ce) ce_cnt++;
        end
        n_chk++;
        if (ce_cnt != 0 || state_out !== 2'b10) begin
            n_err++;
            $display("FAIL step_silent: got %0d pulses state %b expected 0 pulses state 10", ce_cnt, state_out);
        end
        ce_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            step = (i < 15) && ((i % 5) < 2);
            @(negedge clk);
            n_chk++;
            if ({state_out, busy, cpu_ce, cpu_start} !== exp_vec()) begin
                n_err++;
                $display("FAIL step_model cyc %0d: got %b expected %b", i, {state_out, busy, cpu_ce, cpu_start}, exp_vec());
            end
            if (cpu_ce) ce_cnt++;
        end
        n_chk++;
        if (ce_cnt != 3) begin
            n_err++;
            $display("FAIL step_pulses: got %0d expected 3", ce_cnt);
        end
        step_mode = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (state_out !== 2'b01) begin
            n_err++;
            $display("FAIL step_to_run: got %b expected 01", state_out);
        end
    endtask

    task automatic test_halt();
        int ce_cnt = 0;
        int cs_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            halt = (i < 2);
            @(negedge clk);
        end
        n_chk++;
        if (state_out !== 2'b11) begin
            n_err++;
            $display("FAIL halt_enter: got %b expected 11", state_out);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_ce) ce_cnt++;
        end
        n_chk++;
        if (ce_cnt != 0) begin
            n_err++;
            $display("FAIL halt_silent: got %0d pulses expected 0", ce_cnt);
        end
        ce_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step = (i < 2);
            @(negedge clk);
            if (cpu_ce) ce_cnt++;
        end
        n_chk++;
        if (ce_cnt != 1 || state_out !== 2'b11) begin
            n_err++;
            $display("FAIL halt_step: got %0d pulses state %b expected 1 pulse state 11", ce_cnt, state_out);
        end
        for (int i = 0; i < 8; i++) begin
            start = (i < 2);
            @(negedge clk);
            if (cpu_start) cs_cnt++;
        end
        n_chk++;
        if (state_out !== 2'b01 || cs_cnt != 0) begin
            n_err++;
            $display("FAIL halt_resume: got state %b cpu_start count %0d expected 01 0", state_out, cs_cnt);
        end
    endtask

    task automatic test_halt_vs_done();
        int waited = 0;
        int halt_seen = 0;
        while ((m_n % DIV) != DIV - 2 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        n_chk++;
        if ((m_n % DIV) != DIV - 2) begin
            n_err++;
            $display("FAIL prio_align: got phase %0d expected %0d", m_n % DIV, DIV - 2);
        end
        for (int i = 0; i < 6; i++) begin
            halt = (i < 2);
            cpu_ready = (i < 3);
            @(negedge clk);
            if (state_out == 2'b11) halt_seen++;
        end
        n_chk++;
        if (state_out !== 2'b00 || halt_seen != 0) begin
            n_err++;
            $display("FAIL prio_done_halt: got state %b halt cycles %0d expected 00 0", state_out, halt_seen);
        end
    endtask

    task automatic test_reset_pend();
        int first_ce = -1;
        int cs_cnt = 0;
        bit pend_seen = 1'b0;
        step_mode = 1'b0;
        for (int i = 0; i < 10 && !pend_seen; i++) begin
            start = (i < 2);
            @(negedge clk);
            pend_seen = m_pend && (state_out == 2'b00);
        end
        start = 1'b0;
        n_chk++;
        if (!pend_seen) begin
            n_err++;
            $display("FAIL pend_setup: got no pending start window expected one");
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({state_out, busy, cpu_ce, cpu_start} !== 5'b00000) begin
            n_err++;
            $display("FAIL pend_reset_state: got %b expected 00000", {state_out, busy, cpu_ce, cpu_start});
        end
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_ce && first_ce < 0) first_ce = i;
            if (cpu_start || state_out != 2'b00) cs_cnt++;
        end
        n_chk++;
        if (first_ce != DIV || cs_cnt != 0) begin
            n_err++;
            $display("FAIL pend_abort: got first cpu_ce at %0d, %0d bad cycles expected %0d and 0", first_ce, cs_cnt, DIV);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            if ($urandom_range(0, 31) == 0) step_mode = ~step_mode;
            cpu_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n_chk++;
            if ({state_out, busy, cpu_ce, cpu_start} !== exp_vec()) begin
                n_err++;
                $display("FAIL random_model cyc %0d: got %b expected %b", i, {state_out, busy, cpu_ce, cpu_start}, exp_vec());
            end
        end
        reset = 1'b1; start = 1'b0; step = 1'b0; halt = 1'b0; cpu_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_complete();
        test_step_mode();
        test_halt();
        test_halt_vs_done();
        test_reset_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/yasac_run_ctrl.md
YASAC_RUN_CTRL -- requirements
Module: yasac_run_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 25000000, meaning clk cycles per run-mode tick (DIV >= 2).
REQ-002 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  start/resume button, asynchronous to clk.
REQ-005 The block SHALL have port step  input  1  single-step button, asynchronous to clk.
REQ-006 The block SHALL have port halt  input  1  halt button, asynchronous to clk.
REQ-007 The block SHALL have port step_mode  input  1  switch: 1 = single-step execution, 0 = free run.
REQ-008 The block SHALL have port cpu_ready  input  1  processor ready indicator, synchronous to clk.
REQ-009 The block SHALL have port cpu_ce  output  1  processor clock enable, one-cycle pulse.
REQ-010 The block SHALL have port cpu_start  output  1  processor start, high only together with a cpu_ce pulse.
REQ-011 The block SHALL have port state_out  output  2  controller state code.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 start, step and halt SHALL each pass through a 2-FF synchronizer plus rising-edge detector; the edge pulse is one clk cycle wide, high in the cycle after the 2nd clk edge following the input rise; inputs arrive pre-debounced.
REQ-014 Tick counter SHALL count 0..DIV-1 in all states, wrap to 0; tick is high for one cycle when count == DIV-1; width $clog2(DIV).
REQ-015 All outputs SHALL be registered; cpu_ce is asserted the cycle after its triggering event (tick or step edge).
REQ-016 States SHALL be IDLE=00, RUN=01, STEP=10, HALT=11, driven on state_out.
REQ-017 IDLE: cpu_ce follows tick; start edge sets start_pend; the next cpu_ce carries cpu_start=1, clears start_pend, and moves to STEP if step_mode=1, else RUN.
REQ-018 RUN: cpu_ce follows tick; halt edge -> HALT; cpu_ready=1 during a cpu_ce cycle -> IDLE; start edges ignored.
REQ-019 STEP: cpu_ce only on step edges, ticks ignored; step_mode=0 -> RUN; halt edge -> HALT; cpu_ready=1 during a cpu_ce cycle -> IDLE.
REQ-020 HALT: no tick-driven cpu_ce; each step edge yields one cpu_ce and stays in HALT; start edge -> STEP if step_mode=1, else RUN, with cpu_start=0.
REQ-021 Simultaneous events SHALL resolve by priority: completion (cpu_ready on cpu_ce) > halt edge > step_mode change > start edge.
REQ-022 Tick and step edge in the same cycle SHALL produce exactly one cpu_ce pulse.
REQ-023 cpu_start SHALL never assert outside a cpu_ce cycle and never more than once per IDLE exit.

Reset
REQ-024 reset low SHALL asynchronously force state IDLE, tick counter 0, start_pend 0, synchronizer and edge flops 0, cpu_ce 0, cpu_start 0, busy 0, state_out 00.
REQ-025 reset asserted mid-operation SHALL abort any pending start; the first tick after release SHALL be DIV cycles later.

Structure
REQ-026 State encodings SHALL reside as constants in shared package yasac_pkg, reused by the system-level state decoder.
REQ-027 A sub-module sync_edge (2-FF synchronizer + rising-edge pulse) SHALL be instantiated once each for start, step and halt.

Verification (DIV=4)
REQ-028 Reset release, no inputs -> state_out=00, cpu_ce pulses every 4 cycles, cpu_start=0, busy=0.
REQ-029 IDLE, step_mode=0, start pulse -> next cpu_ce carries cpu_start=1, state 01; cpu_ready=1 on a later cpu_ce -> state 00.
REQ-030 step_mode=1, start -> state 10; no cpu_ce for 20 cycles; 3 step pulses -> exactly 3 cpu_ce pulses.
REQ-031 RUN, halt pulse -> state 11, cpu_ce silent; step -> one cpu_ce; start -> state 01, cpu_start stays 0.
REQ-032 RUN, halt edge coincident with cpu_ready=1 on a cpu_ce cycle -> state 00, not 11.
REQ-033 Assert reset with start_pend set, then release -> state 00, no cpu_start, first cpu_ce after 4 cycles.
